vecmac_accum: RTL
=================

VECMAC_ACCUM -- requirements
Module: vecmac_accum

Interface
REQ-001 SHALL have parameter ACCW, default 32, accumulator/result width (>=19).
REQ-002 SHALL have parameter LENW, default 16, width of the beat-count (job length) field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle pulse opening a new dot-product job.
REQ-006 SHALL have port len  input  LENW  beats per job, sampled only when start=1.
REQ-007 SHALL have port in_valid  input  1  partial-sum beat valid; this is the adder-tree out_valid, with no backpressure.
REQ-008 SHALL have port in_sum  input  18  unsigned partial sum of four 8x8 products.
REQ-009 SHALL have port out_valid  output  1  result available at buffer head.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the head result when out_valid=1.
REQ-011 SHALL have port out_acc  output  ACCW  head result value.
REQ-012 SHALL have port out_sat  output  1  head result saturated.
REQ-013 SHALL have port busy  output  1  high while the FSM is not IDLE.
REQ-014 SHALL have port drop_err  output  1  sticky flag: a completed result was lost because the buffer was full.

Function
REQ-015 SHALL implement FSM states IDLE and ACCUM; reset state is IDLE.
REQ-016 SHALL, in IDLE with start=1 and len>=1, latch len, clear acc, count and sat, clear drop_err, and enter ACCUM next cycle.
REQ-017 SHALL ignore start when len=0: state, acc and drop_err unchanged; no result produced.
REQ-018 SHALL ignore in_valid in the start cycle and in IDLE; beats are counted from the cycle after start.
REQ-019 SHALL, in ACCUM, on each in_valid=1, add zero-extended in_sum into acc and increment count.
REQ-020 SHALL saturate acc at 2^ACCW-1 and set sat when any addition overflows; sat stays set for the rest of the job.
REQ-021 SHALL, on the beat where count reaches the latched len, push {sat, final acc} into the output buffer and return to IDLE; the final beat is included in the result.
REQ-022 SHALL, on start=1 in ACCUM with len>=1, abort the job, discard its partial acc, and restart per REQ-016; in this case the abandoned job produces no result.
REQ-023 SHALL provide a 2-entry FIFO output buffer; out_valid = buffer not empty; out_acc/out_sat show the head entry.
REQ-024 SHALL pop the head on out_valid & out_ready.
REQ-025 SHALL make a pushed result visible at the outputs the cycle after the final beat: out_valid=1 on edge N+1 if the final beat is on edge N and the buffer was empty.
REQ-026 SHALL, on a simultaneous push and pop with the buffer full, complete both; no drop occurs and occupancy stays 2.
REQ-027 SHALL, on a push with the buffer full and no pop, discard the new result, set drop_err, and keep existing entries unchanged.
REQ-028 SHALL hold out_acc and out_sat stable while out_valid=1 and out_ready=0.
REQ-029 SHALL keep drop_err set until the next accepted start (len>=1) or reset.
REQ-030 SHALL have a maximum of 2^LENW-1 beats per job; count SHALL NOT wrap within a job.

Reset
REQ-031 SHALL, when rst_n=0 at a clock edge, enter IDLE, empty the buffer, and clear acc, count, sat and drop_err.
REQ-032 SHALL drive out_valid=0, out_acc=0, out_sat=0, busy=0 and drop_err=0 from that edge until the first post-reset event.
REQ-033 SHALL, when reset is asserted mid-job or with results buffered, discard all of them; no result is emitted after reset.

Verification
REQ-034 SHALL be covered: start with len=4, beats 1,2,3,4, out_ready=1 -> one result out_acc=10, out_sat=0, out_valid high one cycle after beat 4, busy low.
REQ-035 SHALL be covered: len=16400, every in_sum=18'h3FFFF -> out_acc=32'hFFFFFFFF, out_sat=1.
REQ-036 SHALL be covered: out_ready=0, three len=1 jobs with sums 5,6,7 -> buffer holds 5 then 6; drop_err=1; raising out_ready then yields 5 and then 6 only.
REQ-037 SHALL be covered: len=3 job, beats 9,9, then start with len=2 and beats 1,2 -> single result out_acc=3.
REQ-038 SHALL be covered: reset pulse after 2 of 4 beats, then beats 2 more -> no out_valid; outputs all zero.
REQ-039 SHALL be covered: start with len=0 plus in_valid beats -> busy stays 0 and no result is produced.

Source files
------------

// File: rtl/vecmac_accum.sv
// rtl/vecmac_accum.sv - saturating dot-product accumulator with a 2-entry result FIFO
// Sums partial-sum beats for len beats per job, then queues {sat, acc} for the consumer.
module vecmac_accum #(
  parameter int ACCW = 32,
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [LENW-1:0] len,
  input  logic            in_valid,
  input  logic [17:0]     in_sum,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_acc,
  output logic            out_sat,
  output logic            busy,
  output logic            drop_err
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t          state_q;
  logic [LENW-1:0] len_q, cnt_q;
  logic [ACCW-1:0] acc_q;
  logic            sat_q, drop_q;
  logic [ACCW:0]   mem_q [2];
  logic            rd_q, wr_q;
  logic [1:0]      fill_q;

  logic [ACCW:0]   sum_d;
  logic [ACCW-1:0] acc_d;
  logic            sat_d;
  logic [LENW-1:0] cnt_d;
  logic            accept_start, beat, last, pop, push, drop;

  always_comb begin
    sum_d        = {1'b0, acc_q} + {{(ACCW-17){1'b0}}, in_sum};
    acc_d        = sum_d[ACCW] ? {ACCW{1'b1}} : sum_d[ACCW-1:0];
    sat_d        = sat_q | sum_d[ACCW];
    cnt_d        = cnt_q + {{(LENW-1){1'b0}}, 1'b1};
    accept_start = start && (len != '0);
    // A restarting job's beat in the start cycle is dropped along with its partial sum
    beat         = (state_q == ACCUM) && in_valid && !accept_start;
    last         = beat && (cnt_d == len_q);
    pop          = (fill_q != 2'd0) && out_ready;
    push         = last && ((fill_q != 2'd2) || pop);
    drop         = last && (fill_q == 2'd2) && !pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      drop_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      fill_q  <= 2'd0;
    end else begin
      if (accept_start) begin
        state_q <= ACCUM;
        len_q   <= len;
        cnt_q   <= '0;
        acc_q   <= '0;
        sat_q   <= 1'b0;
        drop_q  <= 1'b0;
      end else if (beat) begin
        acc_q <= acc_d;
        sat_q <= sat_d;
        cnt_q <= cnt_d;
        if (last) state_q <= IDLE;
      end
      if (drop) drop_q <= 1'b1;
      if (push) begin
        mem_q[wr_q] <= {sat_d, acc_d};
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      fill_q <= fill_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    out_valid = (fill_q != 2'd0);
    out_acc   = out_valid ? mem_q[rd_q][ACCW-1:0] : '0;
    out_sat   = out_valid & mem_q[rd_q][ACCW];
    busy      = (state_q == ACCUM);
    drop_err  = drop_q;
  end

endmodule
